// File: rtl/reset_release_sequencer.sv
// Staged reset release controller.
// All downstream reset domains are held in reset for HOLD_CYCLES after the
// timing reference, then released one by one (bit 0 first) with STAGE_GAP
// cycles between consecutive releases. In RUN, a software request re-asserts
// every stage and restarts the sequence. All outputs come straight from flops.
module reset_release_sequencer #(
    parameter int N_STAGES    = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sw_rst_req,
    output logic [N_STAGES-1:0] stage_rst_n,
    output logic                busy,
    output logic                done,
    output logic                sw_rst_ack
);

    localparam int MAX_COUNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW        = $clog2(MAX_COUNT) + 1;

    localparam logic [CW-1:0]       HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]       GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [N_STAGES-1:0] STAGE_LSB = N_STAGES'(1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [N_STAGES-1:0] stage_q;
    logic                done_q;
    logic                ack_q;

    logic [N_STAGES-1:0] stage_d;
    logic                hold_hit;
    logic                gap_hit;
    logic                last_stage;

    // Next thermometer pattern (one more domain released) and count terminals.
    always_comb begin
        stage_d    = (stage_q << 1) | STAGE_LSB;
        hold_hit   = (cnt_q == HOLD_LAST);
        gap_hit    = (cnt_q == GAP_LAST);
        last_stage = &stage_d;
    end

    // Sequencer FSM: hold interval, stepped release, run / software restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_HOLD: begin
                    if (hold_hit) begin
                        stage_q <= stage_d;
                        cnt_q   <= '0;
                        if (last_stage) begin
                            state_q <= S_RUN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (gap_hit) begin
                        stage_q <= stage_d;
                        cnt_q   <= '0;
                        if (last_stage) begin
                            state_q <= S_RUN;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    cnt_q <= '0;
                    if (sw_rst_req) begin
                        state_q <= S_HOLD;
                        stage_q <= '0;
                        done_q  <= 1'b0;
                        ack_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_HOLD;
                    cnt_q   <= '0;
                    stage_q <= '0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign stage_rst_n = stage_q;
    assign done        = done_q;
    assign busy        = ~done_q;
    assign sw_rst_ack  = ack_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer: default configuration plus a minimal
// N_STAGES=1/HOLD=1/GAP=1 instance driven by the same inputs. Expected
// outputs come from elapsed time since the last timing reference.
module tb_reset_release_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_rst_req = 1'b0;

    logic [3:0] sr0;
    logic       busy0, done0, ack0;
    logic [0:0] sr1;
    logic       busy1, done1, ack1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Per-instance reference state: index 0 = default, 1 = minimal
    int NS [2] = '{4, 1};
    int HC [2] = '{16, 1};
    int GP [2] = '{8, 1};
    int e0 [2];
    bit done_m [2] = '{1'b0, 1'b0};
    bit ack_m  [2];
    int rel_m  [2];

    always #5 clk = ~clk;

    reset_release_sequencer #(
        .N_STAGES(4), .HOLD_CYCLES(16), .STAGE_GAP(8)
    ) u_dut0 (
        .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
        .stage_rst_n(sr0), .busy(busy0), .done(done0), .sw_rst_ack(ack0)
    );

    reset_release_sequencer #(
        .N_STAGES(1), .HOLD_CYCLES(1), .STAGE_GAP(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
        .stage_rst_n(sr1), .busy(busy1), .done(done1), .sw_rst_ack(ack1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Number of released domains t edges after the reference edge.
    function automatic int released(input int t, input int n, input int h, input int g);
        int r;
        if (t < h) return 0;
        r = (t - h) / g + 1;
        return (r > n) ? n : r;
    endfunction

    // Advance the reference model by one clock edge with the given inputs.
    task automatic model_edge(input bit r, input bit s);
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                e0[d]    = cyc;
                ack_m[d] = 1'b0;
            end else if (done_m[d] && s) begin
                e0[d]    = cyc;
                ack_m[d] = 1'b1;
            end else begin
                ack_m[d] = 1'b0;
            end
            rel_m[d]  = released(cyc - e0[d], NS[d], HC[d], GP[d]);
            done_m[d] = (rel_m[d] == NS[d]);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] t0, t1;
        t0 = {28'd0, sr0};
        t1 = {31'd0, sr1};
        chk("stage0", t0, (32'd1 << rel_m[0]) - 32'd1);
        chk("done0",  {31'd0, done0}, {31'd0, done_m[0]});
        chk("busy0",  {31'd0, busy0}, {31'd0, ~done_m[0]});
        chk("ack0",   {31'd0, ack0},  {31'd0, ack_m[0]});
        chk("therm0", t0 & (t0 + 32'd1), 32'd0);
        chk("stage1", t1, (32'd1 << rel_m[1]) - 32'd1);
        chk("done1",  {31'd0, done1}, {31'd0, done_m[1]});
        chk("busy1",  {31'd0, busy1}, {31'd0, ~done_m[1]});
        chk("ack1",   {31'd0, ack1},  {31'd0, ack_m[1]});
        chk("therm1", t1 & (t1 + 32'd1), 32'd0);
    endtask

    // Apply inputs, clock one edge, then compare away from the edge.
    task automatic step(input bit r, input bit s);
        rst        = r;
        sw_rst_req = s;
        @(posedge clk);
        cyc++;
        model_edge(r, s);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        bit r, s;
        int mode;

        // Power-on reset for 5 cycles, then a full release sequence
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        idle(45);

        // Single-cycle software request in RUN
        step(1'b0, 1'b1);
        idle(45);

        // Request during RELEASE (edge 26 after reference) is ignored
        step(1'b0, 1'b1);
        idle(25);
        step(1'b0, 1'b1);
        idle(20);

        // rst mid-RELEASE (edge 30 after reference)
        step(1'b0, 1'b1);
        idle(29);
        step(1'b1, 1'b0);
        idle(45);

        // Request held continuously: periodic re-acceptance
        for (int i = 0; i < 130; i++) step(1'b0, 1'b1);
        idle(45);

        // Randomized traffic mixing pulses, long holds and occasional rst
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 200) == 0) mode = int'($urandom_range(0, 2));
            r = ($urandom_range(0, 249) == 0);
            case (mode)
                0:       s = ($urandom_range(0, 29) == 0);
                1:       s = 1'b1;
                default: s = ($urandom_range(0, 1) == 0);
            endcase
            step(r, s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
